ex2_mac_seq: RTL

- Serial multiply-accumulate sequence engine; parametrised successor of the fixed three-word a*b+c block in the ex2 lab chain.
- Accepts a stream of L = 2*K+1 consecutive valid words: a1,b1,a2,b2,...,aK,bK,c.
- Emits data_out = sum(ai*bi) + c with a one-cycle valido pulse; reports overflow (wrap or saturate) and broken sequences.
- Sits between the lab stimulus source and the result checker/scoreboard.

---
 rtl/ex2_pkg.sv | 35 +++
 rtl/ex2_mac_dp.sv | 44 ++++
 rtl/ex2_mac_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ex2_pkg.sv
// Shared types and helpers for the ex2 serial MAC engine.
// Holds the element-state enum, accumulator sizing and result saturation.
package ex2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_C
  } state_e;

  localparam int MAXW  = 64;
  localparam int MAXAW = 2 * MAXW + 17;

  // K products of two W-bit words plus c never exceed this width.
  function automatic int acc_width(input int w, input int k);
    return 2 * w + $clog2(k) + 1;
  endfunction

  // Returns {ovf, result}; result sits in the low w bits of the low MAXW.
  function automatic logic [MAXW:0] sat_trunc(
    input logic [MAXAW-1:0] fin,
    input int               w,
    input logic             sat
  );
    logic [MAXAW-1:0] mask;
    logic [MAXAW-1:0] res;
    logic             ovf;
    mask = (MAXAW'(1) << w) - MAXAW'(1);
    ovf  = (fin & ~mask) != '0;
    res  = (sat && ovf) ? mask : (fin & mask);
    return {ovf, res[MAXW-1:0]};
  endfunction

endpackage

// File: rtl/ex2_mac_dp.sv
// Datapath: operand-a register, full-width multiplier and accumulator.
// Ports: clear/load_a/mac/fin controls, din word in, final_o = acc + din.
module ex2_mac_dp
  import ex2_pkg::*;
#(
  parameter int W  = 32,
  parameter int AW = 65
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load_a,
  input  logic          mac,
  input  logic          fin,
  input  logic [W-1:0]  din,
  output logic [AW-1:0] final_o
);

  logic [W-1:0]   op_a_q, op_a_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [2*W-1:0] prod;

  always_comb begin
    prod    = {{W{1'b0}}, op_a_q} * {{W{1'b0}}, din};
    final_o = acc_q + AW'(din);
    op_a_d  = op_a_q;
    acc_d   = acc_q;
    if (load_a) op_a_d = din;
    if (mac)    acc_d  = acc_q + AW'(prod);
    // c consumes the sum this edge, so the next sequence starts clean
    if (clear || fin) acc_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q <= '0;
      acc_q  <= '0;
    end else begin
      op_a_q <= op_a_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/ex2_mac_seq.sv
// Serial MAC sequencer: a1,b1..aK,bK,c -> sum(ai*bi)+c with valido pulse.
// Ports: clk, rst, validi, data_in -> valido, data_out, ovf, seq_err, busy.
module ex2_mac_seq
  import ex2_pkg::*;
#(
  parameter int W   = 32,
  parameter int K   = 1,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         validi,
  input  logic [W-1:0] data_in,
  output logic         valido,
  output logic [W-1:0] data_out,
  output logic         ovf,
  output logic         seq_err,
  output logic         busy
);

  localparam int L  = 2 * K + 1;
  localparam int IW = $clog2(L);
  localparam int AW = acc_width(W, K);
  localparam logic [IW-1:0] LAST = IW'(2 * K);

  logic [IW-1:0] idx_q, idx_d;
  logic          valido_q, valido_d;
  logic [W-1:0]  data_out_q, data_out_d;
  logic          ovf_q, ovf_d;
  logic          seq_err_q, seq_err_d;
  logic          busy_q, busy_d;

  logic          clear, load_a, mac, fin;
  logic [AW-1:0] final_w;
  logic [MAXW:0] st;
  state_e        state;

  ex2_mac_dp #(
    .W (W),
    .AW(AW)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .load_a (load_a),
    .mac    (mac),
    .fin    (fin),
    .din    (data_in),
    .final_o(final_w)
  );

  always_comb begin
    state = GET_A;
    unique case (1'b1)
      idx_q == '0:   state = IDLE;
      idx_q == LAST: state = GET_C;
      idx_q[0]:      state = GET_B;
      default:       state = GET_A;
    endcase
  end

  always_comb begin
    st         = sat_trunc(MAXAW'(final_w), W, SAT != 0);
    clear      = 1'b0;
    load_a     = 1'b0;
    mac        = 1'b0;
    fin        = 1'b0;
    idx_d      = idx_q;
    valido_d   = 1'b0;
    seq_err_d  = 1'b0;
    data_out_d = data_out_q;
    ovf_d      = ovf_q;
    if (!validi) begin
      // a gap mid-sequence aborts it; results stay as they were
      if (state != IDLE) begin
        clear     = 1'b1;
        idx_d     = '0;
        seq_err_d = 1'b1;
      end
    end else begin
      unique case (state)
        IDLE, GET_A: begin
          load_a = 1'b1;
          idx_d  = idx_q + IW'(1);
        end
        GET_B: begin
          mac   = 1'b1;
          idx_d = idx_q + IW'(1);
        end
        GET_C: begin
          fin        = 1'b1;
          idx_d      = '0;
          valido_d   = 1'b1;
          data_out_d = st[W-1:0];
          ovf_d      = st[MAXW];
        end
      endcase
    end
    busy_d = idx_d != '0;
  end

  if (W < MAXW) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^st[MAXW-1:W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      valido_q   <= 1'b0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
      seq_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      valido_q   <= valido_d;
      data_out_q <= data_out_d;
      ovf_q      <= ovf_d;
      seq_err_q  <= seq_err_d;
      busy_q     <= busy_d;
    end
  end

  assign valido   = valido_q;
  assign data_out = data_out_q;
  assign ovf      = ovf_q;
  assign seq_err  = seq_err_q;
  assign busy     = busy_q;

endmodule
